// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared encodings for the up/down counter family (counter,
//               prescaler, timer). Mode and direction are single-bit
//               controls, so the named constants document which polarity
//               means what.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Counting mode (mode input)
    localparam logic MODE_WRAP    = 1'b0;  // free-running modulo count
    localparam logic MODE_ONESHOT = 1'b1;  // stop at terminal, raise done

    // Counting direction (up_dn input)
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_term_detect.sv
`default_nettype none
// ============================================================================
// Module      : counter_term_detect
// Description : Combinational terminal-count detector shared by the counter
//               family.
//               Up   : terminal when count >= mod_val. Using >= rather than
//                      == makes an out-of-range count (above mod_val) act as
//                      terminal, so the counter recovers on its next step.
//               Down : terminal when count == 0.
// Ports       : count   [WIDTH] current count value
//               mod_val [WIDTH] terminal value of the up range
//               up_dn   [1]     1 = up, 0 = down
//               term    [1]     terminal condition
// Revision    : 1.0 - initial release
// ============================================================================
module counter_term_detect
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             up_dn,
    output logic             term
);

    logic w_up_term;
    logic w_dn_term;

    assign w_up_term = (count >= mod_val);
    assign w_dn_term = (count == '0);
    assign term      = (up_dn == DIR_UP) ? w_up_term : w_dn_term;

endmodule : counter_term_detect
`default_nettype wire

// File: rtl/counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_mod
// Description : WIDTH-bit synchronous up/down counter with a runtime
//               modulus, WRAP or ONESHOT mode and a sticky done flag.
//               Cascadable: c_out of one stage drives enable of the next.
//               Priority per edge: reset > load > enable > hold.
// Ports       : clk      [1]     rising-edge clock
//               reset    [1]     synchronous active-high reset
//               enable   [1]     count-step request (cascade input)
//               load     [1]     synchronous parallel load
//               load_in  [WIDTH] value loaded when load = 1
//               up_dn    [1]     1 = up, 0 = down
//               mode     [1]     0 = WRAP, 1 = ONESHOT
//               mod_val  [WIDTH] terminal value (up range 0..mod_val)
//               count    [WIDTH] current count (registered)
//               c_out    [1]     terminal-step strobe (combinational)
//               done     [1]     ONESHOT terminal reached (registered, sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_in,
    input  logic             up_dn,
    input  logic             mode,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic             c_out,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_done;
    logic             w_term;
    logic             w_step;

    counter_term_detect #(
        .WIDTH   (WIDTH)
    ) u_term_detect (
        .count   (r_count),
        .mod_val (mod_val),
        .up_dn   (up_dn),
        .term    (w_term)
    );

    // A step is taken only when nothing of higher priority claims the cycle
    // and the one-shot has not already finished.
    assign w_step = enable && !load && !reset && !r_done;

    // Zero-latency strobe so a cascaded stage advances on the same edge
    // this stage wraps.
    assign c_out  = w_term && w_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= RESET_VAL;
            r_done  <= 1'b0;
        end else if (load) begin
            r_count <= load_in;
            r_done  <= 1'b0;
        end else if (enable && !r_done) begin
            if (!w_term) begin
                if (up_dn == DIR_UP) begin
                    r_count <= r_count + c_one;
                end else begin
                    r_count <= r_count - c_one;
                end
            end else if (mode == MODE_ONESHOT) begin
                // Hold at terminal; done keeps the counter frozen until
                // the next load or reset.
                r_done <= 1'b1;
            end else if (up_dn == DIR_UP) begin
                r_count <= '0;
            end else begin
                r_count <= mod_val;
            end
        end
    end

    assign count = r_count;
    assign done  = r_done;

endmodule : counter_updown_mod
`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_updown_mod
// Description : Self-checking bench for counter_updown_mod (WIDTH=4,
//               RESET_VAL=0). Table of per-cycle vectors: inputs are applied
//               after the falling edge and count/c_out/done are compared
//               before the next rising edge, so each row's expected count is
//               the value produced by the previous row. A two-stage cascade
//               is exercised afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       reset, enable, load, up_dn, mode;
    logic [3:0] load_in, mod_val;
    logic [3:0] count;
    logic       c_out, done;

    // Cascade pair
    logic       c_reset, c_enable;
    logic [3:0] s0_count, s1_count;
    logic       s0_c_out, s1_c_out, s0_done, s1_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(4), .RESET_VAL(4'd0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_in(load_in), .up_dn(up_dn), .mode(mode), .mod_val(mod_val),
        .count(count), .c_out(c_out), .done(done)
    );

    counter_updown_mod #(.WIDTH(4), .RESET_VAL(4'd0)) u_s0 (
        .clk(clk), .reset(c_reset), .enable(c_enable), .load(1'b0),
        .load_in(4'd0), .up_dn(1'b1), .mode(1'b0), .mod_val(4'd9),
        .count(s0_count), .c_out(s0_c_out), .done(s0_done)
    );

    counter_updown_mod #(.WIDTH(4), .RESET_VAL(4'd0)) u_s1 (
        .clk(clk), .reset(c_reset), .enable(s0_c_out), .load(1'b0),
        .load_in(4'd0), .up_dn(1'b1), .mode(1'b0), .mod_val(4'd9),
        .count(s1_count), .c_out(s1_c_out), .done(s1_done)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] ld_in;
        logic       en;
        logic       ud;
        logic       md;
        logic [3:0] mv;
        logic [3:0] exp_cnt;
        logic       exp_c;
        logic       exp_d;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ld, input logic [3:0] ld_in,
                       input logic en, input logic ud, input logic md,
                       input logic [3:0] mv, input logic [3:0] exp_cnt,
                       input logic exp_c, input logic exp_d);
        vec_t v;
        v.rst = rst; v.ld = ld; v.ld_in = ld_in; v.en = en; v.ud = ud;
        v.md = md; v.mv = mv; v.exp_cnt = exp_cnt; v.exp_c = exp_c;
        v.exp_d = exp_d;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; load_in = '0;
        up_dn = 1'b1; mode = 1'b0; mod_val = 4'd9;
        c_reset = 1'b1; c_enable = 1'b0;

        //   rst ld ld_in en ud md mv    cnt   c  d
        // Reset state, c_out gated by reset even with enable high
        add(1, 0, 4'd0, 1, 1, 0, 4'd9, 4'd0, 0, 0);
        // 1. Up WRAP mod 9
        for (int k = 0; k < 12; k++)
            add(0, 0, 4'd0, 1, 1, 0, 4'd9, 4'(k % 10), (k == 9), 0);
        // 2. Down WRAP mod 5 from 2 (count 2 arrives after the load row)
        add(0, 1, 4'd2, 0, 0, 0, 4'd5, 4'd2, 0, 0);
        add(0, 0, 4'd0, 1, 0, 0, 4'd5, 4'd2, 0, 0);
        add(0, 0, 4'd0, 1, 0, 0, 4'd5, 4'd1, 0, 0);
        add(0, 0, 4'd0, 1, 0, 0, 4'd5, 4'd0, 1, 0);
        add(0, 0, 4'd0, 1, 0, 0, 4'd5, 4'd5, 0, 0);
        add(0, 0, 4'd0, 1, 0, 0, 4'd5, 4'd4, 0, 0);
        // 3. ONESHOT up mod 3
        add(0, 1, 4'd0, 0, 1, 1, 4'd3, 4'd3, 0, 0);
        add(0, 0, 4'd0, 1, 1, 1, 4'd3, 4'd0, 0, 0);
        add(0, 0, 4'd0, 1, 1, 1, 4'd3, 4'd1, 0, 0);
        add(0, 0, 4'd0, 1, 1, 1, 4'd3, 4'd2, 0, 0);
        add(0, 0, 4'd0, 1, 1, 1, 4'd3, 4'd3, 1, 0);
        add(0, 0, 4'd0, 1, 1, 1, 4'd3, 4'd3, 0, 1);
        add(0, 0, 4'd0, 1, 1, 1, 4'd3, 4'd3, 0, 1);
        // mode/direction change does not clear done
        add(0, 0, 4'd0, 1, 0, 0, 4'd3, 4'd3, 0, 1);
        // load clears done, counting resumes
        add(0, 1, 4'd0, 1, 1, 1, 4'd3, 4'd3, 0, 1);
        add(0, 0, 4'd0, 1, 1, 1, 4'd3, 4'd0, 0, 0);
        // 4. Priority: load beats enable at terminal, then reset
        add(0, 1, 4'd9, 0, 1, 0, 4'd9, 4'd1, 0, 0);
        add(0, 1, 4'd6, 1, 1, 0, 4'd9, 4'd9, 0, 0);
        add(1, 0, 4'd0, 1, 1, 0, 4'd9, 4'd6, 0, 0);
        add(0, 0, 4'd0, 0, 1, 0, 4'd9, 4'd0, 0, 0);
        // Reset while done=1 (ONESHOT, mod 0 terminates immediately)
        add(0, 0, 4'd0, 1, 1, 1, 4'd0, 4'd0, 1, 0);
        add(1, 0, 4'd0, 1, 1, 1, 4'd0, 4'd0, 0, 1);
        add(0, 0, 4'd0, 0, 1, 1, 4'd0, 4'd0, 0, 0);
        // Divide-by-1 in WRAP: mod 0, c_out follows enable
        add(0, 0, 4'd0, 1, 1, 0, 4'd0, 4'd0, 1, 0);
        add(0, 0, 4'd0, 1, 1, 0, 4'd0, 4'd0, 1, 0);
        // 5. Out-of-range: load 12 with mod 4, up wraps to 0
        add(0, 1, 4'd12, 0, 1, 0, 4'd4, 4'd0, 0, 0);
        add(0, 0, 4'd0,  1, 1, 0, 4'd4, 4'd12, 1, 0);
        add(0, 0, 4'd0,  0, 1, 0, 4'd4, 4'd0, 0, 0);
        // down from 12 decrements normally
        add(0, 1, 4'd12, 0, 0, 0, 4'd4, 4'd0, 0, 0);
        add(0, 0, 4'd0,  1, 0, 0, 4'd4, 4'd12, 0, 0);
        add(0, 0, 4'd0,  1, 0, 0, 4'd4, 4'd11, 0, 0);
        add(0, 0, 4'd0,  1, 0, 0, 4'd4, 4'd10, 0, 0);
        add(0, 0, 4'd0,  0, 0, 0, 4'd4, 4'd9, 0, 0);
        // mod 15: plain binary wrap
        add(0, 1, 4'd14, 0, 1, 0, 4'd15, 4'd9, 0, 0);
        add(0, 0, 4'd0,  1, 1, 0, 4'd15, 4'd14, 0, 0);
        add(0, 0, 4'd0,  1, 1, 0, 4'd15, 4'd15, 1, 0);
        add(0, 0, 4'd0,  0, 1, 0, 4'd15, 4'd0, 0, 0);

        // Two reset edges before the table starts
        @(posedge clk);
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset   = vecs[i].rst;
            load    = vecs[i].ld;
            load_in = vecs[i].ld_in;
            enable  = vecs[i].en;
            up_dn   = vecs[i].ud;
            mode    = vecs[i].md;
            mod_val = vecs[i].mv;
            #1;
            check("count", i, 32'(count), 32'(vecs[i].exp_cnt));
            check("c_out", i, 32'(c_out), 32'(vecs[i].exp_c));
            check("done",  i, 32'(done),  32'(vecs[i].exp_d));
        end

        // 6. Cascade: stage1 advances once per 10 clocks; rollover 99 -> 00
        @(negedge clk);
        enable = 1'b0; load = 1'b0; reset = 1'b0;
        c_reset = 1'b1;
        @(negedge clk);
        c_reset  = 1'b0;
        c_enable = 1'b1;
        for (int k = 0; k <= 101; k++) begin
            #1;
            check("s0_count", k, 32'(s0_count), 32'(k % 10));
            check("s1_count", k, 32'(s1_count), 32'((k / 10) % 10));
            check("s0_c_out", k, 32'(s0_c_out), 32'((k % 10) == 9));
            check("s1_c_out", k, 32'(s1_c_out),
                  32'(((k % 10) == 9) && (((k / 10) % 10) == 9)));
            @(negedge clk);
        end
        c_enable = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_updown_mod
`default_nettype wire

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the team's 4-bit loadable counter: WIDTH-bit synchronous up/down counter with a runtime modulus, wrap or one-shot mode, and a registered done flag.
- Used as a cascadable timebase/sequencer in datapath controllers. c_out drives the enable of the next stage.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- RESET_VAL, 0, value loaded into count on reset (WIDTH bits; must be <= the mod_val used after reset).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count-step request. This is the cascade input from the previous stage's c_out.
- load  input  1  synchronous parallel load.
- load_in  input  WIDTH  value loaded when load=1.
- up_dn  input  1  1 = count up, 0 = count down.
- mode  input  1  0 = WRAP (free-running modulo), 1 = ONESHOT (stop at terminal).
- mod_val  input  WIDTH  terminal value. Up-count range is 0..mod_val; down-count reloads to mod_val.
- count  output  WIDTH  current count (registered).
- c_out  output  1  terminal-step strobe (combinational).
- done  output  1  ONESHOT terminal reached (registered, sticky).

Behaviour:
- One clock (clk). Reset is synchronous and active-high: all state changes only on the rising edge of clk.
- Priority each edge is reset > load > enable > hold.
- Reset:
  - count <= RESET_VAL, done <= 0.
  - c_out is 0 during reset because it is gated by !reset.
- Load:
  - count <= load_in; done <= 0.
  - enable and up_dn are ignored that cycle.
  - load_in > mod_val is legal (see out-of-range below).
- Terminal condition:
  - term = (up_dn && count >= mod_val) || (!up_dn && count == 0).
- Step (enable=1, load=0, reset=0, done=0):
  - Up, !term: count <= count + 1.
  - Down, !term: count <= count - 1.
  - Up, term, WRAP: count <= 0.
  - Down, term, WRAP: count <= mod_val.
  - term, ONESHOT: count holds and done <= 1.
- done=1:
  - count holds, and enable is ignored until load or reset.
  - Changing mode or up_dn does not clear done.
- c_out = term && enable && !load && !reset && !done.
  - Exactly one cycle per terminal step, with zero latency relative to enable.
  - In ONESHOT it fires on the same cycle done is being set.
- Arithmetic:
  - Modular in WIDTH bits. No internal wider intermediate is visible.
  - mod_val = 2^WIDTH-1 gives plain binary wrap.
  - mod_val = 0 means count stays 0 and c_out = enable on every step (divide-by-1).
- Out-of-range count (count > mod_val, after a load or a mod_val change):
  - Up: treated as terminal (>= compare), so the next step wraps to 0 or sets done.
  - Down: decrements normally until it reaches 0.
- mod_val and up_dn are sampled every cycle; a change takes effect on the next edge with no pipeline.
- Simultaneous load and enable: load wins, and c_out = 0.
- Reset asserted mid-count or while done=1: identical to power-on reset.
- No X propagation: all registered outputs are defined from the first reset edge.

Decomposition:
- Shared package counter_pkg:
  - MODE_WRAP = 1'b0, MODE_ONESHOT = 1'b1.
  - DIR_UP = 1'b1, DIR_DOWN = 1'b0.
- Sub-module counter_term_detect:
  - Purely combinational. Takes count, mod_val and up_dn; produces term.
  - Reused by the later prescaler/timer blocks.
- Count/done registers stay in the top module.

Test Plan (WIDTH=4, RESET_VAL=0 unless stated):
1. Up WRAP, mod_val=9, enable held high 12 cycles from reset -> count 0,1,...,9,0,1. c_out=1 only on the cycle count=9; done stays 0.
2. Down WRAP, mod_val=5, load_in=2 loaded then enable high -> count 2,1,0,5,4. c_out=1 only while count=0 with enable=1.
3. ONESHOT up, mod_val=3 -> count 0,1,2,3,3,3. c_out pulses once at count=3 and done=1 from the next cycle. A later load of 0 clears done and counting resumes.
4. Priority: at count=9 (mod_val=9, up), assert load=1, load_in=6 and enable=1 together -> count=6 next cycle, c_out=0 that cycle. Then reset=1 with enable=1 -> count=0, done=0, c_out=0.
5. Out-of-range: mod_val=4, load 12, up, enable -> next count 0 with c_out=1 on the step cycle. Repeat down from 12 -> 11,10,...
6. Cascade: two instances, stage0 c_out -> stage1 enable, both mod_val=9 WRAP -> stage1 increments once per 10 clocks. The pair reads 99 then 00, with both c_out high on the rollover cycle.
